// File: rtl/rptr_empty_ctl.sv
// Read-side pointer and status control for an asynchronous FIFO.
// Keeps the binary/Gray read pointers and registers empty, almost-empty, fill level and underflow.
module rptr_empty_ctl #(
    parameter int unsigned ADDRSIZE      = 9,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic                rclr_err,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                runderflow
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext_c;
    logic [PW-1:0] rgraynext_c;
    logic [PW-1:0] wbin_c;
    logic [PW-1:0] count_next_c;
    logic          rd_en_c;
    logic          aempty_next_c;

    // Next read pointer, synchronized write pointer in binary, and next-cycle fill level
    always_comb begin
        rd_en_c       = rinc & ~rempty;
        rbinnext_c    = rbin + PW'(rd_en_c);
        rgraynext_c   = (rbinnext_c >> 1) ^ rbinnext_c;
        wbin_c        = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wbin_c[i] = ^(rq2_wptr >> i);
        end
        count_next_c  = wbin_c - rbinnext_c;
        aempty_next_c = (count_next_c <= PW'(AEMPTY_THRESH));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rcount     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin    <= rbinnext_c;
            rptr    <= rgraynext_c;
            rempty  <= (rgraynext_c == rq2_wptr);
            rcount  <= count_next_c;
            raempty <= aempty_next_c;
            // A read attempt while empty takes priority over a clear in the same cycle
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end else if (rclr_err) begin
                runderflow <= 1'b0;
            end
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_ctl.sv
// Bench for rptr_empty_ctl: directed steps plus a randomized writer/reader stream,
// checked against a count-based FIFO model built on plain integer arithmetic.
module tb_rptr_empty_ctl;

    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;
    localparam int MOD   = 2 * DEPTH;

    logic          rclk;
    logic          rrst_n;
    logic          rinc;
    logic          rclr_err;
    logic [AW:0]   rq2_wptr;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rcount;
    logic          runderflow;

    rptr_empty_ctl #(.ADDRSIZE(AW), .AEMPTY_THRESH(4)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rclr_err   (rclr_err),
        .rq2_wptr   (rq2_wptr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rcount     (rcount),
        .runderflow (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // Model: entries written (m_w) and entries read (m_r) as counts modulo 2*depth
    int m_w, m_r;
    bit m_empty, m_aempty, m_uf;
    int m_count;
    logic [AW:0] prev_rptr;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_r = 0; m_empty = 1'b1; m_aempty = 1'b1; m_count = 0; m_uf = 1'b0;
        prev_rptr = '0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".rptr"},       32'(rptr),       32'(gray(m_r)));
        chk({ph, ".raddr"},      32'(raddr),      32'(m_r % DEPTH));
        chk({ph, ".rempty"},     32'(rempty),     32'(m_empty));
        chk({ph, ".raempty"},    32'(raempty),    32'(m_aempty));
        chk({ph, ".rcount"},     32'(rcount),     32'(m_count));
        chk({ph, ".runderflow"}, 32'(runderflow), 32'(m_uf));
        chk({ph, ".gray_step"},  32'($countones(rptr ^ prev_rptr) <= 1), 32'(1));
        prev_rptr = rptr;
    endtask

    task automatic step(input string ph, input bit inc, input bit clr);
        bit rd;
        rinc     = inc;
        rclr_err = clr;
        rq2_wptr = (AW + 1)'(gray(m_w));
        @(posedge rclk);
        rd       = inc && !m_empty;
        m_uf     = (inc && m_empty) ? 1'b1 : (clr ? 1'b0 : m_uf);
        m_r      = (m_r + int'(rd)) % MOD;
        m_count  = (m_w - m_r + MOD) % MOD;
        m_empty  = (m_count == 0);
        m_aempty = (m_count <= 4);
        #1;
        check_all(ph);
    endtask

    task automatic do_reset(input string ph);
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        rclr_err = 1'b0;
        @(posedge rclk);
        #1;
        model_reset();
        check_all(ph);
        rrst_n = 1'b1;
    endtask

    initial begin
        int  writes;
        int  cycles;
        int  old_r;
        bit  saw_wrap;

        rrst_n = 1'b0; rinc = 1'b0; rclr_err = 1'b0; rq2_wptr = '0;
        m_w = 0;
        model_reset();

        // Reset state with an idle write pointer
        do_reset("reset");
        step("idle", 1'b0, 1'b0);
        chk("idle.rptr_const", 32'(rptr), 32'h000);

        // Three entries arrive, then three reads
        m_w = 3;
        step("fill3", 1'b0, 1'b0);
        chk("fill3.rcount_const", 32'(rcount), 32'd3);
        chk("fill3.raempty_const", 32'(raempty), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("read3.raddr_const", 32'(raddr), 32'(k));
            step("read3", 1'b1, 1'b0);
        end
        chk("read3.rptr_const", 32'(rptr), 32'h002);
        chk("read3.rempty_const", 32'(rempty), 32'd1);

        // Underflow is sticky; set wins over clear
        step("uf_set", 1'b1, 1'b0);
        chk("uf_set.rptr_hold", 32'(rptr), 32'h002);
        step("uf_both", 1'b1, 1'b1);
        chk("uf_both.const", 32'(runderflow), 32'd1);
        step("uf_clr", 1'b0, 1'b1);
        chk("uf_clr.const", 32'(runderflow), 32'd0);

        // Full FIFO from a fresh pointer, then drain past the almost-empty point
        m_w = 0; rq2_wptr = '0;
        do_reset("reset2");
        m_w = DEPTH;
        step("full", 1'b0, 1'b0);
        chk("full.rq2_wptr_gray", 32'(rq2_wptr), 32'h300);
        chk("full.rcount_const", 32'(rcount), 32'd512);
        chk("full.rempty_const", 32'(rempty), 32'd0);
        for (int k = 0; k < 508; k++) step("drain", 1'b1, 1'b0);
        chk("drain.rcount4", 32'(rcount), 32'd4);
        chk("drain.raempty4", 32'(raempty), 32'd1);
        for (int k = 0; k < 4; k++) step("drain_tail", 1'b1, 1'b0);
        chk("drain.empty", 32'(rempty), 32'd1);

        // Random writer/reader stream crossing the pointer wrap
        writes = 0; cycles = 0; saw_wrap = 1'b0;
        while (writes < 1100 && cycles < 20000) begin
            if (((m_w - m_r + MOD) % MOD) < DEPTH && $urandom_range(0, 9) < 6) begin
                m_w = (m_w + 1) % MOD;
                writes++;
            end
            old_r = m_r;
            step("stream", 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            if (old_r == MOD - 1 && m_r == 0) begin
                chk("stream.wrap_rptr", 32'(rptr), 32'h000);
                saw_wrap = 1'b1;
            end
            cycles++;
        end
        chk("stream.writes_done", 32'(writes), 32'd1100);
        chk("stream.saw_wrap", 32'(saw_wrap), 32'd1);

        // Asynchronous reset mid-operation with seven entries pending
        m_w = (m_r + 7) % MOD;
        step("pre_arst", 1'b0, 1'b1);
        chk("pre_arst.rcount7", 32'(rcount), 32'd7);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("arst.rptr",       32'(rptr),       32'd0);
        chk("arst.raddr",      32'(raddr),      32'd0);
        chk("arst.rempty",     32'(rempty),     32'd1);
        chk("arst.raempty",    32'(raempty),    32'd1);
        chk("arst.rcount",     32'(rcount),     32'd0);
        chk("arst.runderflow", 32'(runderflow), 32'd0);
        model_reset();
        @(posedge rclk);
        #1;
        check_all("arst_hold");
        rrst_n = 1'b1;

        // First reads after reset start at address zero
        m_w = 2;
        step("post_rst", 1'b0, 1'b0);
        chk("post_rst.raddr0", 32'(raddr), 32'd0);
        step("post_rd", 1'b1, 1'b0);
        chk("post_rd.raddr1", 32'(raddr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
